// File: rtl/if_id_stage_if.sv
// Instruction-memory fetch bus: request/ready handshake plus a read-data valid strobe.
// One request may be outstanding at a time.
interface if_id_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/if_id_stage.sv
// Instruction fetch plus IF/ID pipeline register for the 16-bit MIPS core: one outstanding
// fetch, skid buffer for responses that land during a decode stall, flush on redirect.
module if_id_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    if_id_stage_if.master         imem,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [15:0]           redirect_pc,
    output logic                  ifid_valid,
    output logic [15:0]           ifid_instr,
    output logic [15:0]           ifid_pc_plus1,
    output logic [3:0]            opcode,
    output logic [2:0]            rs,
    output logic [2:0]            rt,
    output logic [5:0]            imm6,
    output logic                  sext_mode
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_reg,          state_next;
    logic [15:0] pc_reg,             pc_next;
    logic [15:0] skid_reg,           skid_next;
    logic        ifid_valid_reg,     ifid_valid_next;
    logic [15:0] ifid_instr_reg,     ifid_instr_next;
    logic [15:0] ifid_pc_plus1_reg,  ifid_pc_plus1_next;

    logic [15:0] pc_inc;
    logic        load_en;
    logic [15:0] load_data;

    assign pc_inc = pc_reg + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_FETCH;
            pc_reg            <= RESET_PC;
            skid_reg          <= NOP_INSTR;
            ifid_valid_reg    <= 1'b0;
            ifid_instr_reg    <= NOP_INSTR;
            ifid_pc_plus1_reg <= 16'h0000;
        end else begin
            state_reg         <= state_next;
            pc_reg            <= pc_next;
            skid_reg          <= skid_next;
            ifid_valid_reg    <= ifid_valid_next;
            ifid_instr_reg    <= ifid_instr_next;
            ifid_pc_plus1_reg <= ifid_pc_plus1_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        pc_next            = pc_reg;
        skid_next          = skid_reg;
        ifid_valid_next    = ifid_valid_reg;
        ifid_instr_next    = ifid_instr_reg;
        ifid_pc_plus1_next = ifid_pc_plus1_reg;
        load_en            = 1'b0;
        load_data          = skid_reg;

        if (redirect_valid) begin
            // An already-accepted request must still be drained so its response is not
            // mistaken for the first instruction on the new path.
            pc_next         = redirect_pc;
            skid_next       = NOP_INSTR;
            ifid_valid_next = 1'b0;
            ifid_instr_next = NOP_INSTR;
            case (state_reg)
                ST_FETCH: state_next = imem.imem_ready  ? ST_DRAIN : ST_FETCH;
                ST_WAIT:  state_next = imem.imem_rvalid ? ST_FETCH : ST_DRAIN;
                ST_HOLD:  state_next = ST_FETCH;
                ST_DRAIN: state_next = imem.imem_rvalid ? ST_FETCH : ST_DRAIN;
                default:  state_next = ST_FETCH;
            endcase
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (imem.imem_ready) begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (stall) begin
                            skid_next  = imem.imem_rdata;
                            state_next = ST_HOLD;
                        end else begin
                            load_en    = 1'b1;
                            load_data  = imem.imem_rdata;
                            state_next = ST_FETCH;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        load_en    = 1'b1;
                        load_data  = skid_reg;
                        state_next = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem.imem_rvalid) begin
                        state_next = ST_FETCH;
                    end
                end
                default: state_next = ST_FETCH;
            endcase

            if (load_en) begin
                ifid_valid_next    = 1'b1;
                ifid_instr_next    = load_data;
                ifid_pc_plus1_next = pc_inc;
                pc_next            = pc_inc;
            end else if (!stall) begin
                // Nothing new for decode this cycle: insert a bubble.
                ifid_valid_next = 1'b0;
                ifid_instr_next = NOP_INSTR;
            end
        end
    end

    // Request is gated by reset so nothing is issued while the core is held in reset.
    assign imem.imem_req  = rst_n && (state_reg == ST_FETCH);
    assign imem.imem_addr = pc_reg;

    assign ifid_valid    = ifid_valid_reg;
    assign ifid_instr    = ifid_instr_reg;
    assign ifid_pc_plus1 = ifid_pc_plus1_reg;
    assign opcode        = ifid_instr_reg[15:12];
    assign rs            = ifid_instr_reg[11:9];
    assign rt            = ifid_instr_reg[8:6];
    assign imm6          = ifid_instr_reg[5:0];
    assign sext_mode     = ~ifid_instr_reg[15];

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: memory responder with variable latency, queue-based
// reference model of in-flight fetches, vector table, directed corner sequences, random run.
module tb_if_id_stage;

    localparam logic [15:0] NOP = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus1;
    logic [3:0]  opcode;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [5:0]  imm6;
    logic        sext_mode;

    if_id_stage_if bus ();

    if_id_stage #(.RESET_PC(16'h0000), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc_plus1  (ifid_pc_plus1),
        .opcode         (opcode),
        .rs             (rs),
        .rt             (rt),
        .imm6           (imm6),
        .sext_mode      (sext_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory responder knobs: rdy_mode 0=random 1=always 2=never; lat_mode 0=random 1=fixed.
    int          rdy_mode = 2;
    int          lat_mode = 1;
    int          lat_fix  = 1;
    bit          force_en = 0;
    logic [15:0] force_data = 16'h0000;
    bit          r_busy = 0;
    int          r_cnt  = 0;
    logic [15:0] r_addr = 16'h0000;

    // Reference model: PC, IF/ID contents, queue of in-flight fetches (1 = still wanted),
    // and an optional instruction parked while decode is stalled.
    logic [15:0] m_pc;
    logic        m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_pp1;
    bit          m_live[$];
    bit          m_pend_v;
    logic [15:0] m_pend_d;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
        logic [15:0] pp1;
        logic [3:0]  op;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [5:0]  imm;
        logic        sext;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 16'h0000;
        m_valid  = 1'b0;
        m_instr  = NOP;
        m_pp1    = 16'h0000;
        m_live.delete();
        m_pend_v = 1'b0;
        m_pend_d = NOP;
        r_busy   = 1'b0;
        r_cnt    = 0;
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return force_en ? force_data : ((a * 16'h9E37) ^ 16'h5A5A);
    endfunction

    // One clock cycle: drive memory, check pre-edge request, advance model, check IF/ID.
    task automatic tick();
        bit          accepted;
        bit          acc_dut;
        logic [15:0] acc_addr;
        bit          rv;
        logic [15:0] rd;
        bit          got;
        bit          live_resp;
        bit          load;
        logic [15:0] ld;
        int          lat;

        rv = r_busy && (r_cnt == 0);
        rd = rv ? mem_word(r_addr) : 16'($urandom);
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        case (rdy_mode)
            1:       bus.imem_ready = 1'b1;
            2:       bus.imem_ready = 1'b0;
            default: bus.imem_ready = ($urandom_range(0, 9) < 7);
        endcase
        lat = (lat_mode == 1) ? lat_fix : int'($urandom_range(1, 4));
        #1;

        chk("imem_req", 32'(bus.imem_req), 32'((m_live.size() == 0) && !m_pend_v));
        chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
        accepted = (m_live.size() == 0) && !m_pend_v && bus.imem_ready;
        acc_dut  = bus.imem_req && bus.imem_ready;
        acc_addr = bus.imem_addr;

        got = 0;
        live_resp = 0;
        if (rv && m_live.size() > 0) begin
            live_resp = m_live.pop_front();
            got = 1;
        end
        if (redirect_valid) begin
            m_pc     = redirect_pc;
            m_valid  = 1'b0;
            m_instr  = NOP;
            m_pend_v = 1'b0;
            foreach (m_live[i]) m_live[i] = 1'b0;
            if (accepted) m_live.push_back(1'b0);
        end else begin
            load = 0;
            ld   = NOP;
            if (got && live_resp) begin
                if (stall) begin
                    m_pend_v = 1'b1;
                    m_pend_d = rd;
                end else begin
                    load = 1;
                    ld   = rd;
                end
            end else if (m_pend_v && !stall) begin
                load     = 1;
                ld       = m_pend_d;
                m_pend_v = 1'b0;
            end
            if (load) begin
                m_instr = ld;
                m_valid = 1'b1;
                m_pp1   = m_pc + 16'd1;
                m_pc    = m_pc + 16'd1;
            end else if (!stall) begin
                m_valid = 1'b0;
                m_instr = NOP;
            end
            if (accepted) m_live.push_back(1'b1);
        end

        @(posedge clk);
        #1;
        if (rv) r_busy = 1'b0;
        else if (r_busy && r_cnt > 0) r_cnt--;
        if (acc_dut) begin
            r_busy = 1'b1;
            r_cnt  = lat - 1;
            r_addr = acc_addr;
        end

        chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
        chk("ifid_instr", 32'(ifid_instr), 32'(m_instr));
        chk("opcode",     32'(opcode),     32'(m_instr >> 12));
        chk("rs",         32'(rs),         32'((m_instr >> 9) & 16'd7));
        chk("rt",         32'(rt),         32'((m_instr >> 6) & 16'd7));
        chk("imm6",       32'(imm6),       32'(m_instr & 16'd63));
        chk("sext_mode",  32'(sext_mode),  32'(m_instr < 16'h8000));
        if (m_valid) chk("ifid_pc_plus1", 32'(ifid_pc_plus1), 32'(m_pp1));
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        rdy_mode       = 2;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic fetch_one(input logic [15:0] data);
        bit done;
        done       = 0;
        force_en   = 1;
        force_data = data;
        rdy_mode   = 1;
        lat_mode   = 1;
        lat_fix    = 1;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (ifid_valid) done = 1;
        end
        chk("fetch_done", 32'(done), 32'd1);
        rdy_mode = 2;
    endtask

    initial begin
        logic [15:0] s_instr;
        logic [15:0] s_pp1;
        logic [15:0] x_pc;
        bit          idle;

        vecs[0] = '{16'h0010, 16'hB03F, 16'h0011, 4'hB, 3'd0, 3'd0, 6'h3F, 1'b0};
        vecs[1] = '{16'h0100, 16'h1234, 16'h0101, 4'h1, 3'd1, 3'd0, 6'h34, 1'b1};
        vecs[2] = '{16'h7FFF, 16'hFFFF, 16'h8000, 4'hF, 3'd7, 3'd7, 6'h3F, 1'b0};
        vecs[3] = '{16'h1230, 16'h7FC0, 16'h1231, 4'h7, 3'd7, 3'd7, 6'h00, 1'b1};
        vecs[4] = '{16'hFFFE, 16'h8E01, 16'hFFFF, 4'h8, 3'd7, 3'd0, 6'h01, 1'b0};
        vecs[5] = '{16'hABCD, 16'h3A7F, 16'hABCE, 4'h3, 3'd5, 3'd1, 6'h3F, 1'b1};

        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 16'h0000;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 16'h0000;
        model_reset();

        #3;
        chk("rst_req",   32'(bus.imem_req),   32'd0);
        chk("rst_addr",  32'(bus.imem_addr),  32'h0000);
        chk("rst_valid", 32'(ifid_valid),     32'd0);
        chk("rst_instr", 32'(ifid_instr),     32'(NOP));
        chk("rst_pp1",   32'(ifid_pc_plus1),  32'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First fetch out of reset: accept, then response one cycle later.
        fetch_one(16'h3A7F);
        chk("t1_instr", 32'(ifid_instr),    32'h3A7F);
        chk("t1_imm6",  32'(imm6),          32'h3F);
        chk("t1_sext",  32'(sext_mode),     32'd1);
        chk("t1_pp1",   32'(ifid_pc_plus1), 32'h0001);
        chk("t1_addr",  32'(bus.imem_addr), 32'h0001);

        for (int v = 0; v < 6; v++) begin
            do_redirect(vecs[v].pc);
            fetch_one(vecs[v].data);
            chk("vec_instr", 32'(ifid_instr),    32'(vecs[v].data));
            chk("vec_pp1",   32'(ifid_pc_plus1), 32'(vecs[v].pp1));
            chk("vec_op",    32'(opcode),        32'(vecs[v].op));
            chk("vec_rs",    32'(rs),            32'(vecs[v].rs));
            chk("vec_rt",    32'(rt),            32'(vecs[v].rt));
            chk("vec_imm6",  32'(imm6),          32'(vecs[v].imm));
            chk("vec_sext",  32'(sext_mode),     32'(vecs[v].sext));
            chk("vec_addr",  32'(bus.imem_addr), 32'(vecs[v].pp1));
        end

        // Stall across the response: IF/ID frozen, response parked, released afterwards.
        s_instr    = ifid_instr;
        s_pp1      = ifid_pc_plus1;
        x_pc       = bus.imem_addr;
        force_data = 16'h1234;
        lat_fix    = 2;
        rdy_mode   = 1;
        stall      = 1'b1;
        tick();
        rdy_mode = 2;
        for (int i = 0; i < 3; i++) begin
            chk("stall_instr", 32'(ifid_instr),    32'(s_instr));
            chk("stall_valid", 32'(ifid_valid),    32'd1);
            chk("stall_pp1",   32'(ifid_pc_plus1), 32'(s_pp1));
            chk("stall_req",   32'(bus.imem_req),  32'd0);
            tick();
        end
        chk("stall_instr", 32'(ifid_instr), 32'(s_instr));
        stall = 1'b0;
        tick();
        chk("unstall_instr", 32'(ifid_instr),    32'h1234);
        chk("unstall_valid", 32'(ifid_valid),    32'd1);
        chk("unstall_pp1",   32'(ifid_pc_plus1), 32'(x_pc + 16'd1));
        chk("unstall_addr",  32'(bus.imem_addr), 32'(x_pc + 16'd1));

        // Redirect while waiting: the late response must be discarded.
        force_data = 16'hFFFF;
        lat_fix    = 3;
        rdy_mode   = 1;
        tick();
        do_redirect(16'h0040);
        chk("drain_valid", 32'(ifid_valid),   32'd0);
        chk("drain_req",   32'(bus.imem_req), 32'd0);
        tick();
        tick();
        chk("drop_valid", 32'(ifid_valid),    32'd0);
        chk("drop_instr", 32'(ifid_instr),    32'(NOP));
        chk("drop_addr",  32'(bus.imem_addr), 32'h0040);
        chk("drop_req",   32'(bus.imem_req),  32'd1);

        // Redirect together with stall while the response sits in the skid buffer.
        force_data = 16'h2222;
        lat_fix    = 1;
        rdy_mode   = 1;
        stall      = 1'b1;
        tick();
        tick();
        do_redirect(16'h0123);
        chk("hold_rd_valid", 32'(ifid_valid),    32'd0);
        chk("hold_rd_instr", 32'(ifid_instr),    32'(NOP));
        chk("hold_rd_addr",  32'(bus.imem_addr), 32'h0123);
        stall = 1'b0;
        fetch_one(16'h4444);
        chk("hold_rd_fetch", 32'(ifid_instr),    32'h4444);
        chk("hold_rd_pp1",   32'(ifid_pc_plus1), 32'h0124);

        // Randomised traffic against the reference model.
        force_en = 0;
        rdy_mode = 0;
        lat_mode = 0;
        for (int i = 0; i < 2000; i++) begin
            stall          = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 99) < 8);
            redirect_pc    = 16'($urandom);
            tick();
        end
        stall          = 1'b0;
        redirect_valid = 1'b0;
        rdy_mode       = 2;
        idle           = 0;
        for (int i = 0; i < 20 && !idle; i++) begin
            tick();
            idle = (m_live.size() == 0) && !m_pend_v;
        end
        chk("drain_idle", 32'(idle), 32'd1);

        // PC wrap, then reset while a fetch is outstanding.
        do_redirect(16'hFFFF);
        fetch_one(16'h1111);
        chk("wrap_pp1",  32'(ifid_pc_plus1), 32'h0000);
        chk("wrap_addr", 32'(bus.imem_addr), 32'h0000);
        do_redirect(16'h0555);
        lat_fix  = 3;
        rdy_mode = 1;
        tick();
        rdy_mode = 2;
        chk("pre_rst_req", 32'(bus.imem_req), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_req",   32'(bus.imem_req),  32'd0);
        chk("arst_addr",  32'(bus.imem_addr), 32'h0000);
        chk("arst_valid", 32'(ifid_valid),    32'd0);
        chk("arst_instr", 32'(ifid_instr),    32'(NOP));
        chk("arst_pp1",   32'(ifid_pc_plus1), 32'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("post_rst_req", 32'(bus.imem_req), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
